// File: rtl/nice_gemm_dma.sv
// NICE GEMM operand DMA: round-robin ICB command issue over NCH read channels
// plus one result-write channel, with an in-order tag FIFO for responses.
module nice_gemm_dma #(
    parameter int NCH    = 4,
    parameter int MAX_OS = 2,
    parameter int LEN_W  = 16,
    parameter int BUF_AW = 9,
    localparam int CSW   = $clog2(NCH + 1)
) (
    input  logic              nice_clk,
    input  logic              nice_rst,
    input  logic              cfg_we,
    input  logic [CSW-1:0]    cfg_sel,
    input  logic [31:0]       cfg_base,
    input  logic [15:0]       cfg_stride,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              buf_wr_valid,
    output logic [CSW-1:0]    buf_wr_ch,
    output logic [BUF_AW-1:0] buf_wr_addr,
    output logic [31:0]       buf_wr_data,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [31:0]       res_data,
    output logic              nice_icb_cmd_valid,
    input  logic              nice_icb_cmd_ready,
    output logic [31:0]       nice_icb_cmd_addr,
    output logic              nice_icb_cmd_read,
    output logic [31:0]       nice_icb_cmd_wdata,
    output logic [1:0]        nice_icb_cmd_size,
    output logic              nice_mem_holdup,
    input  logic              nice_icb_rsp_valid,
    output logic              nice_icb_rsp_ready,
    input  logic [31:0]       nice_icb_rsp_rdata,
    input  logic              nice_icb_rsp_err
);

    localparam int NC = NCH + 1;
    localparam int PW = (MAX_OS > 1) ? $clog2(MAX_OS) : 1;
    localparam int CW = $clog2(MAX_OS + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [CSW-1:0] WCH = CSW'(NCH);

    logic [1:0]        state_q, state_d;
    logic [31:0]       base_q   [NC];
    logic [31:0]       base_d   [NC];
    logic [15:0]       stride_q [NC];
    logic [15:0]       stride_d [NC];
    logic [LEN_W-1:0]  len_q    [NC];
    logic [LEN_W-1:0]  len_d    [NC];
    logic [LEN_W-1:0]  rem_q    [NC];
    logic [LEN_W-1:0]  rem_d    [NC];
    logic [31:0]       addr_q   [NC];
    logic [31:0]       addr_d   [NC];
    logic [BUF_AW-1:0] idx_q    [NC];
    logic [BUF_AW-1:0] idx_d    [NC];

    logic              cmd_valid_q, cmd_valid_d;
    logic [31:0]       cmd_addr_q, cmd_addr_d;
    logic              cmd_read_q, cmd_read_d;
    logic [31:0]       cmd_wdata_q, cmd_wdata_d;
    logic [CSW-1:0]    cmd_ch_q, cmd_ch_d;
    logic [BUF_AW-1:0] cmd_idx_q, cmd_idx_d;

    logic [CSW-1:0]    tag_ch_q  [MAX_OS];
    logic [CSW-1:0]    tag_ch_d  [MAX_OS];
    logic [BUF_AW-1:0] tag_idx_q [MAX_OS];
    logic [BUF_AW-1:0] tag_idx_d [MAX_OS];
    logic [PW-1:0]     wp_q, wp_d;
    logic [PW-1:0]     rp_q, rp_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [CSW-1:0]    rr_q, rr_d;
    logic              err_q, err_d;

    logic [NC-1:0]     elig;
    logic              gnt_any;
    logic [CSW-1:0]    gnt_ch;
    logic              can_issue;
    logic              grant;
    logic              cmd_hs;
    logic              pop;
    logic              rsp_fail;
    logic              all_zero;
    logic              quiet;
    logic              finish;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (int'(p) == MAX_OS - 1) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        all_zero = 1'b1;
        for (int c = 0; c < NC; c++) begin
            elig[c] = (rem_q[c] != '0) && ((c != NCH) || res_valid);
            if (rem_q[c] != '0) all_zero = 1'b0;
        end
    end

    // Search starts one past the last grant so every channel gets a turn.
    always_comb begin
        int c;
        c       = 0;
        gnt_any = 1'b0;
        gnt_ch  = rr_q;
        for (int i = 1; i <= NC; i++) begin
            c = (int'(rr_q) + i) % NC;
            if (!gnt_any && elig[c]) begin
                gnt_any = 1'b1;
                gnt_ch  = CSW'(c);
            end
        end
    end

    assign cmd_hs   = cmd_valid_q && nice_icb_cmd_ready;
    assign pop      = nice_icb_rsp_valid && (cnt_q != '0);
    assign rsp_fail = pop && nice_icb_rsp_err;
    assign quiet    = !cmd_valid_q && (cnt_q == '0);
    assign finish   = ((state_q == S_RUN) && all_zero && quiet)
                   || ((state_q == S_DRAIN) && quiet);

    assign can_issue = (state_q == S_RUN) && !rsp_fail
                    && (!cmd_valid_q || nice_icb_cmd_ready)
                    && (int'(cnt_q) + int'(cmd_valid_q) < MAX_OS);
    assign grant     = can_issue && gnt_any;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        stride_d    = stride_q;
        len_d       = len_q;
        rem_d       = rem_q;
        addr_d      = addr_q;
        idx_d       = idx_q;
        cmd_valid_d = cmd_valid_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_read_d  = cmd_read_q;
        cmd_wdata_d = cmd_wdata_q;
        cmd_ch_d    = cmd_ch_q;
        cmd_idx_d   = cmd_idx_q;
        tag_ch_d    = tag_ch_q;
        tag_idx_d   = tag_idx_q;
        wp_d        = wp_q;
        rp_d        = rp_q;
        cnt_d       = cnt_q;
        rr_d        = rr_q;
        err_d       = err_q;

        if (rsp_fail) err_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (cfg_we && (cfg_sel <= WCH)) begin
                    base_d[cfg_sel]   = cfg_base;
                    stride_d[cfg_sel] = cfg_stride;
                    len_d[cfg_sel]    = cfg_len;
                end
                if (start) begin
                    state_d = S_RUN;
                    err_d   = 1'b0;
                    for (int c = 0; c < NC; c++) begin
                        rem_d[c]  = len_q[c];
                        addr_d[c] = base_q[c];
                        idx_d[c]  = '0;
                    end
                end
            end
            S_RUN: begin
                if (rsp_fail) state_d = S_DRAIN;
                else if (finish) state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (finish) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (cmd_hs) cmd_valid_d = 1'b0;

        if (grant) begin
            cmd_valid_d    = 1'b1;
            cmd_addr_d     = addr_q[gnt_ch];
            cmd_read_d     = (gnt_ch != WCH);
            cmd_wdata_d    = (gnt_ch == WCH) ? res_data : 32'h0;
            cmd_ch_d       = gnt_ch;
            cmd_idx_d      = idx_q[gnt_ch];
            rem_d[gnt_ch]  = rem_q[gnt_ch] - 1'b1;
            addr_d[gnt_ch] = addr_q[gnt_ch] + {16'h0, stride_q[gnt_ch]};
            idx_d[gnt_ch]  = idx_q[gnt_ch] + 1'b1;
            rr_d           = gnt_ch;
        end

        if (cmd_hs) begin
            tag_ch_d[wp_q]  = cmd_ch_q;
            tag_idx_d[wp_q] = cmd_idx_q;
            wp_d            = ptr_inc(wp_q);
        end
        if (pop) rp_d = ptr_inc(rp_q);

        if (cmd_hs && !pop) cnt_d = cnt_q + 1'b1;
        else if (!cmd_hs && pop) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge nice_clk) begin
        if (nice_rst) begin
            state_q <= S_IDLE;
            for (int c = 0; c < NC; c++) begin
                base_q[c]   <= '0;
                stride_q[c] <= '0;
                len_q[c]    <= '0;
                rem_q[c]    <= '0;
                addr_q[c]   <= '0;
                idx_q[c]    <= '0;
            end
            cmd_valid_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_read_q  <= 1'b0;
            cmd_wdata_q <= '0;
            cmd_ch_q    <= '0;
            cmd_idx_q   <= '0;
            for (int t = 0; t < MAX_OS; t++) begin
                tag_ch_q[t]  <= '0;
                tag_idx_q[t] <= '0;
            end
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            rr_q  <= WCH;
            err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            stride_q    <= stride_d;
            len_q       <= len_d;
            rem_q       <= rem_d;
            addr_q      <= addr_d;
            idx_q       <= idx_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_read_q  <= cmd_read_d;
            cmd_wdata_q <= cmd_wdata_d;
            cmd_ch_q    <= cmd_ch_d;
            cmd_idx_q   <= cmd_idx_d;
            tag_ch_q    <= tag_ch_d;
            tag_idx_q   <= tag_idx_d;
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            cnt_q       <= cnt_d;
            rr_q        <= rr_d;
            err_q       <= err_d;
        end
    end

    // Outputs are forced quiet for the whole cycle reset is high.
    assign busy               = (state_q != S_IDLE) && !nice_rst;
    assign done               = finish && !nice_rst;
    assign err                = err_q && !nice_rst;
    assign nice_mem_holdup    = busy;
    assign res_ready          = grant && (gnt_ch == WCH) && !nice_rst;
    assign nice_icb_cmd_valid = cmd_valid_q && !nice_rst;
    assign nice_icb_cmd_addr  = cmd_addr_q;
    assign nice_icb_cmd_read  = cmd_read_q;
    assign nice_icb_cmd_wdata = cmd_wdata_q;
    assign nice_icb_cmd_size  = 2'b10;
    assign nice_icb_rsp_ready = 1'b1;
    assign buf_wr_valid       = pop && (tag_ch_q[rp_q] != WCH) && !nice_rst;
    assign buf_wr_ch          = tag_ch_q[rp_q];
    assign buf_wr_addr        = tag_idx_q[rp_q];
    assign buf_wr_data        = nice_icb_rsp_rdata;

endmodule

// File: tb/tb_nice_gemm_dma.sv
// Directed bench for nice_gemm_dma: ICB slave with 1-cycle responses,
// result-stream producer and negedge monitors, one task per scenario.
module tb_nice_gemm_dma;

    logic        clk;
    logic        nice_rst;
    logic        cfg_we;
    logic [2:0]  cfg_sel;
    logic [31:0] cfg_base;
    logic [15:0] cfg_stride;
    logic [15:0] cfg_len;
    logic        start;
    logic        busy, done, err;
    logic        buf_wr_valid;
    logic [2:0]  buf_wr_ch;
    logic [8:0]  buf_wr_addr;
    logic [31:0] buf_wr_data;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic        cmd_valid, cmd_ready, cmd_read;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [1:0]  cmd_size;
    logic        holdup;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    nice_gemm_dma dut (
        .nice_clk           (clk),
        .nice_rst           (nice_rst),
        .cfg_we             (cfg_we),
        .cfg_sel            (cfg_sel),
        .cfg_base           (cfg_base),
        .cfg_stride         (cfg_stride),
        .cfg_len            (cfg_len),
        .start              (start),
        .busy               (busy),
        .done               (done),
        .err                (err),
        .buf_wr_valid       (buf_wr_valid),
        .buf_wr_ch          (buf_wr_ch),
        .buf_wr_addr        (buf_wr_addr),
        .buf_wr_data        (buf_wr_data),
        .res_valid          (res_valid),
        .res_ready          (res_ready),
        .res_data           (res_data),
        .nice_icb_cmd_valid (cmd_valid),
        .nice_icb_cmd_ready (cmd_ready),
        .nice_icb_cmd_addr  (cmd_addr),
        .nice_icb_cmd_read  (cmd_read),
        .nice_icb_cmd_wdata (cmd_wdata),
        .nice_icb_cmd_size  (cmd_size),
        .nice_mem_holdup    (holdup),
        .nice_icb_rsp_valid (rsp_valid),
        .nice_icb_rsp_ready (rsp_ready),
        .nice_icb_rsp_rdata (rsp_rdata),
        .nice_icb_rsp_err   (rsp_err)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] ca_log [$];
    logic        cr_log [$];
    logic [31:0] cw_log [$];
    logic [2:0]  bc_log [$];
    logic [8:0]  ba_log [$];
    logic [31:0] bd_log [$];
    logic [31:0] rspq   [$];
    int done_cnt, rr_cnt, max_out, infl, rsp_num, res_seq;
    int stall_left, err_at, stab_bad;
    logic rsp_hold, res_toggle, prev_stall;
    logic [31:0] prev_addr, prev_wdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    always @(posedge clk) begin
        #1;
        cmd_ready = (stall_left == 0);
        if (!rsp_hold && rspq.size() > 0) begin
            rsp_valid = 1'b1;
            rsp_rdata = rspq[0];
            rsp_err   = (err_at != 0) && (rsp_num + 1 == err_at);
        end else begin
            rsp_valid = 1'b0;
            rsp_rdata = 32'h0;
            rsp_err   = 1'b0;
        end
        if (res_toggle) res_valid = !res_valid;
        res_data = 32'hD000_0000 + res_seq;
    end

    always @(negedge clk) begin
        if (!nice_rst) begin
            if (cmd_valid && prev_stall
                && (cmd_addr !== prev_addr || cmd_wdata !== prev_wdata))
                stab_bad++;
            prev_stall = cmd_valid && !cmd_ready;
            prev_addr  = cmd_addr;
            prev_wdata = cmd_wdata;
            if (infl + int'(cmd_valid) > max_out)
                max_out = infl + int'(cmd_valid);
            if (cmd_valid && cmd_ready) begin
                ca_log.push_back(cmd_addr);
                cr_log.push_back(cmd_read);
                cw_log.push_back(cmd_wdata);
                rspq.push_back(~cmd_addr);
                infl++;
            end
            if (stall_left > 0 && cmd_valid && !cmd_ready) stall_left--;
            if (buf_wr_valid) begin
                bc_log.push_back(buf_wr_ch);
                ba_log.push_back(buf_wr_addr);
                bd_log.push_back(buf_wr_data);
            end
            if (done) done_cnt++;
            if (res_ready) begin
                rr_cnt++;
                if (res_valid) res_seq++;
            end
        end
        if (rsp_valid) begin
            void'(rspq.pop_front());
            infl--;
            rsp_num++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs;
        ca_log.delete(); cr_log.delete(); cw_log.delete();
        bc_log.delete(); ba_log.delete(); bd_log.delete();
        done_cnt = 0; rr_cnt = 0; max_out = 0; stab_bad = 0;
        rsp_num = 0;
    endtask

    task automatic cfg(input logic [2:0] s, input logic [31:0] b,
                       input logic [15:0] st, input logic [15:0] l);
        cfg_we = 1'b1; cfg_sel = s; cfg_base = b;
        cfg_stride = st; cfg_len = l;
        tick;
        cfg_we = 1'b0;
    endtask

    task automatic cfg_zero;
        for (int s = 0; s < 5; s++) cfg(3'(s), 32'h0, 16'h0, 16'h0);
    endtask

    task automatic run_wait(input string nm, input int budget);
        int n;
        n = 0;
        start = 1'b1;
        tick;
        start = 1'b0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL %s_done_timeout got 0 exp done within %0d", nm, budget);
        end
        tick;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({busy, done, err, cmd_valid, buf_wr_valid, res_ready} !== 6'b0) begin
            errors++;
            $display("FAIL rst_outs got %b exp 000000",
                     {busy, done, err, cmd_valid, buf_wr_valid, res_ready});
        end
        @(posedge clk); #1;
        nice_rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || holdup !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy got %b/%b exp 0/0", busy, holdup);
        end
        checks++;
        if (rsp_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_rsp_ready got %b exp 1", rsp_ready);
        end
        checks++;
        if (cmd_size !== 2'b10) begin
            errors++;
            $display("FAIL cmd_size got %b exp 10", cmd_size);
        end
        tick;
    endtask

    task automatic test_zero_len;
        clear_logs;
        start = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL zl_busy_T got %b exp 0", busy);
        end
        tick;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL zl_T1 got busy=%b done=%b exp 1/1", busy, done);
        end
        tick;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL zl_T2 got busy=%b done=%b exp 0/0", busy, done);
        end
        tick;
    endtask

    task automatic test_round_robin;
        logic [31:0] ea [8];
        logic [2:0]  ec [8];
        logic [8:0]  ei [8];
        ea = '{32'h1000, 32'h2000, 32'h3000, 32'h4000,
               32'h1004, 32'h2004, 32'h3004, 32'h4004};
        ec = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3};
        ei = '{9'd0, 9'd0, 9'd0, 9'd0, 9'd1, 9'd1, 9'd1, 9'd1};
        for (int c = 0; c < 4; c++) cfg(3'(c), 32'((c + 1) << 12), 16'd4, 16'd2);
        clear_logs;
        run_wait("rr", 100);
        checks++;
        if (ca_log.size() != 8 || bc_log.size() != 8) begin
            errors++;
            $display("FAIL rr_count got %0d/%0d exp 8/8", ca_log.size(), bc_log.size());
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (ca_log[i] !== ea[i] || bc_log[i] !== ec[i]
                || ba_log[i] !== ei[i] || bd_log[i] !== ~ea[i]) begin
                errors++;
                $display("FAIL rr_%0d got a=%h ch=%0d i=%0d d=%h exp a=%h ch=%0d i=%0d",
                         i, ca_log[i], bc_log[i], ba_log[i], bd_log[i], ea[i], ec[i], ei[i]);
            end
        end
        checks++;
        if (max_out > 2) begin
            errors++;
            $display("FAIL rr_outstanding got %0d exp <=2", max_out);
        end
    endtask

    task automatic test_single;
        logic [31:0] ea [3];
        logic [31:0] ed [3];
        ea = '{32'h1000, 32'h1004, 32'h1008};
        ed = '{32'hFFFF_EFFF, 32'hFFFF_EFFB, 32'hFFFF_EFF7};
        cfg_zero;
        cfg(3'd0, 32'h1000, 16'd4, 16'd3);
        clear_logs;
        run_wait("single", 50);
        checks++;
        if (ca_log.size() != 3 || bc_log.size() != 3) begin
            errors++;
            $display("FAIL single_count got %0d/%0d exp 3/3", ca_log.size(), bc_log.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ca_log[i] !== ea[i] || cr_log[i] !== 1'b1 || bc_log[i] !== 3'd0
                || ba_log[i] !== 9'(i) || bd_log[i] !== ed[i]) begin
                errors++;
                $display("FAIL single_%0d got a=%h r=%b ch=%0d i=%0d d=%h exp a=%h d=%h",
                         i, ca_log[i], cr_log[i], bc_log[i], ba_log[i], bd_log[i], ea[i], ed[i]);
            end
        end
        checks++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done got cnt=%0d busy=%b exp 1/0", done_cnt, busy);
        end
    endtask

    task automatic test_write;
        cfg_zero;
        cfg(3'd4, 32'h2000, 16'd4, 16'd2);
        clear_logs;
        stall_left = 3;
        res_toggle = 1'b1;
        run_wait("wr", 100);
        res_toggle = 1'b0;
        res_valid = 1'b0;
        checks++;
        if (ca_log.size() != 2) begin
            errors++;
            $display("FAIL wr_count got %0d exp 2", ca_log.size());
        end
        checks++;
        if (ca_log[0] !== 32'h2000 || ca_log[1] !== 32'h2004
            || cr_log[0] !== 1'b0 || cr_log[1] !== 1'b0) begin
            errors++;
            $display("FAIL wr_addr got %h/%h r=%b%b exp 2000/2004 r=00",
                     ca_log[0], ca_log[1], cr_log[0], cr_log[1]);
        end
        checks++;
        if (cw_log[0] !== 32'hD000_0000 || cw_log[1] !== 32'hD000_0001) begin
            errors++;
            $display("FAIL wr_wdata got %h/%h exp d0000000/d0000001", cw_log[0], cw_log[1]);
        end
        checks++;
        if (rr_cnt != 2) begin
            errors++;
            $display("FAIL wr_res_ready got %0d exp 2", rr_cnt);
        end
        checks++;
        if (stab_bad != 0 || stall_left != 0) begin
            errors++;
            $display("FAIL wr_stall got unstable=%0d left=%0d exp 0/0", stab_bad, stall_left);
        end
        checks++;
        if (bc_log.size() != 0) begin
            errors++;
            $display("FAIL wr_bufwr got %0d exp 0", bc_log.size());
        end
    endtask

    task automatic test_error;
        cfg_zero;
        cfg(3'd0, 32'h3000, 16'd4, 16'd4);
        clear_logs;
        err_at = 2;
        run_wait("err", 50);
        err_at = 0;
        checks++;
        if (ca_log.size() != 2) begin
            errors++;
            $display("FAIL err_cmds got %0d exp 2", ca_log.size());
        end
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || done_cnt != 1) begin
            errors++;
            $display("FAIL err_end got err=%b busy=%b done=%0d exp 1/0/1", err, busy, done_cnt);
        end
        repeat (3) tick;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got %b exp 1", err);
        end
        cfg(3'd0, 32'h0, 16'h0, 16'h0);
        start = 1'b1;
        tick;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear got %b exp 0", err);
        end
        tick;
        tick;
    endtask

    task automatic test_reset_midflight;
        int n;
        cfg(3'd0, 32'h4000, 16'd4, 16'd4);
        clear_logs;
        rsp_hold = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        n = 0;
        while (ca_log.size() < 2 && n < 20) begin
            tick;
            n++;
        end
        tick;
        checks++;
        if (ca_log.size() != 2) begin
            errors++;
            $display("FAIL mid_inflight got %0d exp 2", ca_log.size());
        end
        nice_rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cmd_valid !== 1'b0 || buf_wr_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst got busy=%b cv=%b bw=%b exp 0/0/0", busy, cmd_valid, buf_wr_valid);
        end
        tick;
        nice_rst = 1'b0;
        clear_logs;
        rsp_hold = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_cv got %b exp 0", cmd_valid);
        end
        repeat (5) tick;
        checks++;
        if (bc_log.size() != 0 || ca_log.size() != 0) begin
            errors++;
            $display("FAIL mid_late got bufwr=%0d cmds=%0d exp 0/0", bc_log.size(), ca_log.size());
        end
        checks++;
        if (busy !== 1'b0 || done_cnt != 0) begin
            errors++;
            $display("FAIL mid_idle got busy=%b done=%0d exp 0/0", busy, done_cnt);
        end
    endtask

    initial begin
        nice_rst = 1'b1;
        cfg_we = 1'b0; cfg_sel = '0; cfg_base = '0;
        cfg_stride = '0; cfg_len = '0; start = 1'b0;
        res_valid = 1'b0; res_data = '0;
        cmd_ready = 1'b1; rsp_valid = 1'b0;
        rsp_rdata = '0; rsp_err = 1'b0;
        done_cnt = 0; rr_cnt = 0; max_out = 0; infl = 0;
        rsp_num = 0; res_seq = 0; stall_left = 0; err_at = 0;
        stab_bad = 0; rsp_hold = 1'b0; res_toggle = 1'b0;
        prev_stall = 1'b0; prev_addr = '0; prev_wdata = '0;
        tick;
        test_reset;
        test_zero_len;
        test_round_robin;
        test_single;
        test_write;
        test_error;
        test_reset_midflight;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
